hazard_control_unit: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage pipeline (F, D, E, M, W).
- Drives the stall and clear inputs of every stage pipeline register, including the Execute-stage register's CLR.
- Selects the Execute-stage operand forwarding paths.
- Sequences data-memory wait states, with a timeout that halts the pipeline on a hung memory.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_control_unit_if.sv | 33 +++
 rtl/hazard_control_unit.sv | 140 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard bus: stage register/control inputs to the hazard controller
// and the stall/flush/forward/status outputs it returns.
interface hazard_control_unit_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       rs1_D, rs2_D;
   logic [4:0]       rs1_E, rs2_E, rd_E;
   logic [2:0]       result_src_E;
   logic             pc_src_E;
   logic [4:0]       rd_M, rd_W;
   logic             reg_write_M, reg_write_W;
   logic             mem_req_M;
   logic             dmem_ready_M;
   logic             stall_F, stall_D, stall_E, stall_M;
   logic             flush_D, flush_E, flush_W;
   logic [1:0]       forward_a_E, forward_b_E;
   logic             mem_error;
   logic [CNT_W-1:0] stall_count, flush_count;

   modport slave (
      input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, result_src_E, pc_src_E,
      input  rd_M, rd_W, reg_write_M, reg_write_W, mem_req_M, dmem_ready_M,
      output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
      output forward_a_E, forward_b_E, mem_error, stall_count, flush_count
   );

   modport master (
      output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, result_src_E, pc_src_E,
      output rd_M, rd_W, reg_write_M, reg_write_W, mem_req_M, dmem_ready_M,
      input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
      input  forward_a_E, forward_b_E, mem_error, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush/forwarding controller for a 5-stage pipeline, with data-memory
// wait sequencing, hung-memory timeout and saturating performance counters.
module hazard_control_unit #(
   parameter logic [2:0]  LOAD_SRC = 3'b001,
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                  CLK,
   input  logic                  CLR,
   hazard_control_unit_if.slave  hz
);
   localparam int unsigned WcW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [WcW-1:0] WaitLast = WcW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {StRun, StWait, StHalt} state_e;

   state_e           state_q, state_d;
   logic [WcW-1:0]   wait_cnt_q, wait_cnt_d;
   logic             mem_error_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic       memwait, lw, timeout;
   logic       stall_f, stall_d, stall_e, stall_m;
   logic       flush_d, flush_e, flush_w;
   logic       branch_flush;
   logic [1:0] fwd_a, fwd_b;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                          input logic [4:0] rd_m, input logic wr_w,
                                          input logic [4:0] rd_w);
      if (wr_m && rd_m != 5'd0 && rd_m == rs) begin
         return 2'b10;
      end else if (wr_w && rd_w != 5'd0 && rd_w == rs) begin
         return 2'b01;
      end
      return 2'b00;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(hz.rs1_E, hz.reg_write_M, hz.rd_M, hz.reg_write_W, hz.rd_W);
      fwd_b = fwd_sel(hz.rs2_E, hz.reg_write_M, hz.rd_M, hz.reg_write_W, hz.rd_W);
   end

   assign memwait = hz.mem_req_M && !hz.dmem_ready_M;
   assign lw      = (hz.result_src_E == LOAD_SRC) && (hz.rd_E != 5'd0) &&
                    ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
   assign timeout = memwait && (wait_cnt_q == WaitLast);

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = memwait ? wait_cnt_q + WcW'(1) : '0;
      stall_f      = 1'b0;
      stall_d      = 1'b0;
      stall_e      = 1'b0;
      stall_m      = 1'b0;
      flush_d      = 1'b0;
      flush_e      = 1'b0;
      flush_w      = 1'b0;
      branch_flush = 1'b0;

      if (state_q == StHalt) begin
         // Frozen until reset; hold the counter so it cannot wrap.
         wait_cnt_d = wait_cnt_q;
         stall_f    = 1'b1;
         stall_d    = 1'b1;
         stall_e    = 1'b1;
         stall_m    = 1'b1;
         flush_w    = 1'b1;
      end else if (memwait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (hz.pc_src_E) begin
         flush_d      = 1'b1;
         flush_e      = 1'b1;
         branch_flush = 1'b1;
      end else if (lw) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end

      case (state_q)
         StRun: begin
            if (timeout) begin
               state_d = StHalt;
            end else if (memwait) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (timeout) begin
               state_d = StHalt;
            end else if (!memwait) begin
               state_d = StRun;
            end
         end
         StHalt:  state_d = StHalt;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         mem_error_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (state_d == StHalt) begin
            mem_error_q <= 1'b1;
         end
         if (stall_f && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (branch_flush && flush_cnt_q != '1) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   // Reset forces every pipeline control quiet, independent of the inputs.
   assign hz.stall_F     = stall_f & ~CLR;
   assign hz.stall_D     = stall_d & ~CLR;
   assign hz.stall_E     = stall_e & ~CLR;
   assign hz.stall_M     = stall_m & ~CLR;
   assign hz.flush_D     = flush_d & ~CLR;
   assign hz.flush_E     = flush_e & ~CLR;
   assign hz.flush_W     = flush_w & ~CLR;
   assign hz.forward_a_E = CLR ? 2'b00 : fwd_a;
   assign hz.forward_b_E = CLR ? 2'b00 : fwd_b;
   assign hz.mem_error   = mem_error_q;
   assign hz.stall_count = stall_cnt_q;
   assign hz.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomised scoreboard bench for hazard_control_unit: a driver pushes the
// expected response of an abstract model, a monitor pops and compares it.
module tb_hazard_control_unit;
   localparam int unsigned MAX_WAIT = 4;
   localparam int unsigned CNT_W    = 8;
   localparam int          CNT_MAX  = (1 << CNT_W) - 1;

   typedef struct {
      logic       clr;
      logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
      logic [2:0] result_src_E;
      logic       pc_src_E, reg_write_M, reg_write_W, mem_req_M, dmem_ready_M;
   } stim_t;

   typedef struct {
      int stalls;   // {F,D,E,M}
      int flushes;  // {D,E,W}
      int fwd_a;
      int fwd_b;
      int err;
      int scnt;
      int fcnt;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   // Model state: consecutive memory-wait cycles, halted flag, counters.
   int m_run = 0;
   bit m_halt = 0;
   int m_err = 0;
   int m_scnt = 0;
   int m_fcnt = 0;

   hazard_control_unit_if #(.CNT_W(CNT_W)) hz ();

   hazard_control_unit #(
      .LOAD_SRC (3'b001),
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) dut (
      .CLK (clk),
      .CLR (clr),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s.clr = 1'b0;
      s.rs1_D = 5'd0; s.rs2_D = 5'd0; s.rs1_E = 5'd0; s.rs2_E = 5'd0;
      s.rd_E = 5'd0; s.rd_M = 5'd0; s.rd_W = 5'd0;
      s.result_src_E = 3'd0;
      s.pc_src_E = 1'b0; s.reg_write_M = 1'b0; s.reg_write_W = 1'b0;
      s.mem_req_M = 1'b0; s.dmem_ready_M = 1'b1;
      return s;
   endfunction

   function automatic int fwd(input stim_t s, input logic [4:0] rs);
      if (s.reg_write_M && s.rd_M != 0 && s.rd_M == rs) return 2;
      if (s.reg_write_W && s.rd_W != 0 && s.rd_W == rs) return 1;
      return 0;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   // Apply one cycle of stimulus after the edge and predict the response.
   task automatic step(input stim_t s);
      exp_t e;
      bit   memwait, lw, taken;
      @(posedge clk);
      #1;
      clr = s.clr;
      hz.rs1_D = s.rs1_D; hz.rs2_D = s.rs2_D; hz.rs1_E = s.rs1_E; hz.rs2_E = s.rs2_E;
      hz.rd_E = s.rd_E; hz.rd_M = s.rd_M; hz.rd_W = s.rd_W;
      hz.result_src_E = s.result_src_E; hz.pc_src_E = s.pc_src_E;
      hz.reg_write_M = s.reg_write_M; hz.reg_write_W = s.reg_write_W;
      hz.mem_req_M = s.mem_req_M; hz.dmem_ready_M = s.dmem_ready_M;

      if (s.clr) begin
         m_run = 0; m_halt = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
         e = '{stalls: 0, flushes: 0, fwd_a: 0, fwd_b: 0, err: 0, scnt: 0, fcnt: 0};
         sb_q.push_back(e);
         return;
      end

      memwait = s.mem_req_M && !s.dmem_ready_M;
      lw = s.result_src_E == 3'b001 && s.rd_E != 0 &&
           (s.rd_E == s.rs1_D || s.rd_E == s.rs2_D);
      taken = 0;
      e.stalls = 0; e.flushes = 0;
      if (m_halt || memwait) begin
         e.stalls = 15; e.flushes = 1;
      end else if (s.pc_src_E) begin
         e.flushes = 6; taken = 1;
      end else if (lw) begin
         e.stalls = 12; e.flushes = 2;
      end
      e.fwd_a = fwd(s, s.rs1_E);
      e.fwd_b = fwd(s, s.rs2_E);
      e.err   = m_err;
      e.scnt  = m_scnt;
      e.fcnt  = m_fcnt;
      sb_q.push_back(e);

      if (e.stalls[3] && m_scnt < CNT_MAX) m_scnt++;
      if (taken && m_fcnt < CNT_MAX) m_fcnt++;
      if (!m_halt) begin
         m_run = memwait ? m_run + 1 : 0;
         if (m_run >= MAX_WAIT) begin
            m_halt = 1;
            m_err = 1;
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("stalls_FDEM", {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M}, e.stalls);
            chk("flushes_DEW", {hz.flush_D, hz.flush_E, hz.flush_W}, e.flushes);
            chk("forward_a_E", hz.forward_a_E, e.fwd_a);
            chk("forward_b_E", hz.forward_b_E, e.fwd_b);
            chk("mem_error", hz.mem_error, e.err);
            chk("stall_count", hz.stall_count, e.scnt);
            chk("flush_count", hz.flush_count, e.fcnt);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      stim_t s;
      int    hang;
      s = idle();
      s.clr = 1'b1;
      step(s);
      step(s);

      // Forwarding priority
      s = idle();
      s.rd_M = 5; s.rd_W = 5; s.rs1_E = 5; s.rs2_E = 5;
      s.reg_write_M = 1; s.reg_write_W = 1;
      step(s);
      s.reg_write_M = 0;
      step(s);
      s.rd_M = 0; s.rd_W = 0; s.reg_write_M = 1;
      step(s);

      // Load-use, then a harmless load to x0
      s = idle();
      s.result_src_E = 3'b001; s.rd_E = 3; s.rs2_D = 3;
      step(s);
      step(idle());
      s.rd_E = 0; s.rs2_D = 0;
      step(s);

      // Branch beats load-use
      s = idle();
      s.result_src_E = 3'b001; s.rd_E = 3; s.rs2_D = 3; s.pc_src_E = 1;
      step(s);
      step(idle());

      // Memory wait of three cycles with a branch held in place
      s = idle();
      s.mem_req_M = 1; s.dmem_ready_M = 0;
      step(s);
      s.pc_src_E = 1;
      step(s);
      s.pc_src_E = 0;
      step(s);
      s.dmem_ready_M = 1; s.pc_src_E = 1;
      step(s);
      step(idle());

      // Timeout into halt, recovery only through reset
      s = idle();
      s.mem_req_M = 1; s.dmem_ready_M = 0;
      repeat (6) step(s);
      s.dmem_ready_M = 1; s.pc_src_E = 1;
      repeat (3) step(s);
      s = idle();
      s.clr = 1;
      step(s);
      step(idle());

      // Randomised traffic with occasional hung memory and resets
      hang = 0;
      for (int i = 0; i < 1500; i++) begin
         s = idle();
         s.clr = ($urandom_range(0, 80) == 0);
         s.rs1_D = 5'($urandom_range(0, 3)); s.rs2_D = 5'($urandom_range(0, 3));
         s.rs1_E = 5'($urandom_range(0, 3)); s.rs2_E = 5'($urandom_range(0, 3));
         s.rd_E = 5'($urandom_range(0, 3)); s.rd_M = 5'($urandom_range(0, 3));
         s.rd_W = 5'($urandom_range(0, 3));
         s.result_src_E = $urandom_range(0, 1) ? 3'b001 : 3'($urandom_range(0, 7));
         s.pc_src_E = ($urandom_range(0, 4) == 0);
         s.reg_write_M = 1'($urandom_range(0, 1));
         s.reg_write_W = 1'($urandom_range(0, 1));
         if (hang == 0 && $urandom_range(0, 60) == 0) hang = $urandom_range(2, 6);
         s.mem_req_M = (hang > 0) || ($urandom_range(0, 2) == 0);
         s.dmem_ready_M = (hang > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (hang > 0) hang--;
         step(s);
      end

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
